// File: rtl/result_pkg.sv
// rtl/result_pkg.sv - shared state type, delay-depth and row-index helpers for result_deskew
package result_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DRAIN   = 2'd2,
        DONE    = 2'd3
    } state_e;

    localparam int MATRIX_SIZE_DEF = 2;

    // Column c leaves the array c cycles after column 0, so it needs the complementary delay.
    function automatic int delay_depth(input int n, input int col);
        return n - 1 - col;
    endfunction

    function automatic int row_idx_width(input int n);
        return $clog2(n) + 1;
    endfunction

    localparam int ROW_IDX_W = row_idx_width(MATRIX_SIZE_DEF);

endpackage

// File: rtl/row_fifo.sv
// rtl/row_fifo.sv - synchronous FIFO for assembled rows; push while full is accepted only with a pop
module row_fifo
    import result_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] rdata_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_q, wr_d, rd_q, rd_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    // The extra pointer bit tells a full buffer apart from an empty one.
    assign empty_o = (wr_q == rd_q);
    assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign wr_d    = do_push ? wr_q + 1'b1 : wr_q;
    assign rd_d    = do_pop  ? rd_q + 1'b1 : rd_q;
    assign rdata_o = mem_q[rd_q[AW-1:0]];

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_q[AW-1:0]] <= wdata_i;
        end
    end

endmodule

// File: rtl/result_deskew.sv
// rtl/result_deskew.sv - deskews systolic column results into rows, buffers them; RESULT_ROWCHECK_EN adds row-count check
module result_deskew
    import result_pkg::*;
#(
    parameter int MATRIX_SIZE = MATRIX_SIZE_DEF,
    parameter int DATA_SIZE   = 32,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               general_enable,
    input  logic                               start,
    input  logic [MATRIX_SIZE-1:0]             col_valid,
    input  logic [MATRIX_SIZE*DATA_SIZE-1:0]   col_data,
    input  logic                               sched_done,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [MATRIX_SIZE*DATA_SIZE-1:0]   out_data,
    output logic [row_idx_width(MATRIX_SIZE)-1:0] out_row_idx,
    output logic                               all_rows_out,
    output logic                               overflow,
    output logic                               skew_err,
    output logic                               row_count_err
);

    localparam int N     = MATRIX_SIZE;
    localparam int DW    = DATA_SIZE;
    localparam int IDX_W = row_idx_width(MATRIX_SIZE);

    logic [N-1:0]    aligned_v;
    logic [N*DW-1:0] aligned_d;
    logic [N-1:0]    stage_any;

    for (genvar c = 0; c < N; c++) begin : g_col
        localparam int D = delay_depth(N, c);
        if (D == 0) begin : g_pass
            assign aligned_v[c]           = col_valid[c];
            assign aligned_d[c*DW +: DW]  = col_data[c*DW +: DW];
            assign stage_any[c]           = 1'b0;
        end else begin : g_dly
            logic [D-1:0]  v_q;
            logic [DW-1:0] d_q [D];
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    v_q <= '0;
                    for (int k = 0; k < D; k++) d_q[k] <= '0;
                end else if (general_enable) begin
                    v_q[0] <= col_valid[c];
                    d_q[0] <= col_data[c*DW +: DW];
                    for (int k = 1; k < D; k++) begin
                        v_q[k] <= v_q[k-1];
                        d_q[k] <= d_q[k-1];
                    end
                end
            end
            assign aligned_v[c]          = v_q[D-1];
            assign aligned_d[c*DW +: DW] = d_q[D-1];
            assign stage_any[c]          = |v_q;
        end
    end

    logic push_w, skew_hit, pop_w, fifo_full, fifo_empty;
    logic [N*DW-1:0] fifo_rdata;

    assign push_w   = general_enable && (&aligned_v);
    assign skew_hit = general_enable && (|aligned_v) && !(&aligned_v);
    assign pop_w    = out_valid && out_ready;

    row_fifo #(.WIDTH(N*DW), .DEPTH(FIFO_DEPTH)) u_row_fifo (
        .clk_i   (clk),
        .reset_i (reset),
        .push_i  (push_w),
        .pop_i   (pop_w),
        .wdata_i (aligned_d),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .rdata_o (fifo_rdata)
    );

    assign out_valid = !fifo_empty;
    assign out_data  = fifo_empty ? '0 : fifo_rdata;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             ovf_q, ovf_d, skew_q, skew_d, all_q, all_d, enter_done;

    always_comb begin
        state_d = state_q;
        idx_d   = pop_w ? idx_q + 1'b1 : idx_q;
        ovf_d   = ovf_q | (push_w & fifo_full & ~pop_w);
        skew_d  = skew_q | skew_hit;
        case (state_q)
            IDLE:    if (general_enable && (|col_valid)) state_d = COLLECT;
            COLLECT: if (sched_done) state_d = DRAIN;
            DRAIN:   if (!(|stage_any) && fifo_empty && !push_w) state_d = DONE;
            default: state_d = state_q;
        endcase
        // start restarts bookkeeping only; buffered rows survive it.
        if (start) begin
            state_d = IDLE;
            idx_d   = '0;
            ovf_d   = 1'b0;
            skew_d  = 1'b0;
        end
        all_d      = (state_d == DONE);
        enter_done = (state_q != DONE) && (state_d == DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            ovf_q   <= 1'b0;
            skew_q  <= 1'b0;
            all_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            ovf_q   <= ovf_d;
            skew_q  <= skew_d;
            all_q   <= all_d;
        end
    end

    assign out_row_idx  = idx_q;
    assign all_rows_out = all_q;
    assign overflow     = ovf_q;
    assign skew_err     = skew_q;

`ifdef RESULT_ROWCHECK_EN
    logic rce_q, rce_d;

    always_comb begin
        rce_d = rce_q;
        if (enter_done && (idx_q != IDX_W'(N))) rce_d = 1'b1;
        if (start) rce_d = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) rce_q <= 1'b0;
        else       rce_q <= rce_d;
    end

    assign row_count_err = rce_q;
`else
    assign row_count_err = 1'b0;
`endif

endmodule

// File: tb/tb_result_deskew.sv
// tb/tb_result_deskew.sv - self-checking bench for result_deskew: vector table, corner sequences, random vs model
module tb_result_deskew;

    localparam int N     = 2;
    localparam int DW    = 32;
    localparam int DEPTH = 4;

    logic            clk = 1'b0;
    logic            reset, general_enable, start, sched_done, out_ready;
    logic [N-1:0]    col_valid;
    logic [N*DW-1:0] col_data;
    logic            out_valid, all_rows_out, overflow, skew_err, row_count_err;
    logic [N*DW-1:0] out_data;
    logic [1:0]      out_row_idx;

    always #5 clk = ~clk;

    result_deskew #(.MATRIX_SIZE(N), .DATA_SIZE(DW), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .general_enable(general_enable), .start(start),
        .col_valid(col_valid), .col_data(col_data), .sched_done(sched_done),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_row_idx(out_row_idx), .all_rows_out(all_rows_out), .overflow(overflow),
        .skew_err(skew_err), .row_count_err(row_count_err)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference model: history of enabled-cycle samples, queue of rows, spec-level phase.
    typedef struct packed {
        logic [N-1:0]    v;
        logic [N*DW-1:0] d;
    } samp_t;

    samp_t           hist[$];
    logic [N*DW-1:0] mq[$];
    int              m_phase, m_idx;
    bit              m_ovf, m_skew, m_rce;

    logic            smp_valid, smp_all, smp_ovf, smp_skew, smp_rce;
    logic [N*DW-1:0] smp_data;
    logic [1:0]      smp_idx;

    function automatic void model_reset();
        hist.delete();
        mq.delete();
        m_phase = 0; m_idx = 0; m_ovf = 0; m_skew = 0; m_rce = 0;
    endfunction

    task automatic tick();
        logic [N-1:0]    av;
        logic [N*DW-1:0] ad;
        bit lines, push, pop;
        int d;
        if (reset) model_reset();
        @(negedge clk);
        smp_valid = out_valid; smp_data = out_data; smp_idx = out_row_idx;
        smp_all = all_rows_out; smp_ovf = overflow; smp_skew = skew_err; smp_rce = row_count_err;
        chk("m_out_valid", out_valid, mq.size() > 0);
        if (mq.size() > 0) chk("m_out_data", out_data, mq[0]);
        chk("m_row_idx", out_row_idx, m_idx[1:0]);
        chk("m_all_rows_out", all_rows_out, m_phase == 3);
        chk("m_overflow", overflow, m_ovf);
        chk("m_skew_err", skew_err, m_skew);
        chk("m_row_count_err", row_count_err, m_rce);
        if (!reset) begin
            av = '0; ad = '0; lines = 0;
            for (int c = 0; c < N; c++) begin
                d = N - 1 - c;
                if (d == 0) begin
                    av[c] = col_valid[c];
                    ad[c*DW +: DW] = col_data[c*DW +: DW];
                end else if (hist.size() >= d) begin
                    av[c] = hist[hist.size()-d].v[c];
                    ad[c*DW +: DW] = hist[hist.size()-d].d[c*DW +: DW];
                end
                for (int j = 1; j <= d; j++)
                    if (hist.size() >= j && hist[hist.size()-j].v[c]) lines = 1;
            end
            push = general_enable && (&av);
            pop  = (mq.size() > 0) && out_ready;
            if (general_enable && (|av) && !(&av)) m_skew = 1;
            case (m_phase)
                0: if (general_enable && (|col_valid)) m_phase = 1;
                1: if (sched_done) m_phase = 2;
                2: if (!lines && mq.size() == 0 && !push) begin
                       m_phase = 3;
`ifdef RESULT_ROWCHECK_EN
                       if (m_idx != N) m_rce = 1;
`endif
                   end
                default: ;
            endcase
            if (pop) begin
                void'(mq.pop_front());
                m_idx++;
            end
            if (push) begin
                if (mq.size() < DEPTH) mq.push_back(ad);
                else m_ovf = 1;
            end
            if (start) begin
                m_phase = 0; m_idx = 0; m_ovf = 0; m_skew = 0; m_rce = 0;
            end
            if (general_enable) begin
                hist.push_back('{v: col_valid, d: col_data});
                while (hist.size() > N - 1) void'(hist.pop_front());
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        general_enable = 1'b1; start = 1'b0; sched_done = 1'b0;
        col_valid = '0; col_data = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Row r = {base+2r+1, base+2r}, fed with column 1 one cycle after column 0.
    task automatic feed_rows(input int n, input logic [31:0] base);
        logic [31:0] a, b;
        for (int k = 0; k <= n; k++) begin
            a = base + 32'(2*k);
            b = base + 32'(2*k - 1);
            col_valid = {(k > 0), (k < n)};
            col_data  = {b, a};
            tick();
        end
        col_valid = '0;
        col_data  = '0;
    endtask

    task automatic drain(output int cnt, output logic [63:0] first, output logic [63:0] last);
        out_ready = 1'b1;
        col_valid = '0;
        cnt = 0; first = '0; last = '0;
        repeat (8) begin
            tick();
            if (smp_valid) begin
                if (cnt == 0) first = smp_data;
                last = smp_data;
                cnt++;
            end
        end
    endtask

    typedef struct {
        logic        en;
        logic [1:0]  v;
        logic [31:0] c0, c1;
        logic        rdy, done;
        logic        e_ov;
        logic [31:0] e_d0, e_d1;
        logic [1:0]  e_idx;
        logic        e_all;
    } vec_t;

    vec_t tbl[9];
    int   cnt;
    logic [63:0] first, last;
    bit   got;

    initial begin
        tbl[0] = '{1'b1, 2'b01, 32'h11, 32'h0,  1'b1, 1'b0, 1'b0, 32'h0,  32'h0,  2'd0, 1'b0};
        tbl[1] = '{1'b1, 2'b10, 32'h0,  32'h22, 1'b1, 1'b0, 1'b0, 32'h0,  32'h0,  2'd0, 1'b0};
        tbl[2] = '{1'b1, 2'b00, 32'h0,  32'h0,  1'b1, 1'b0, 1'b1, 32'h11, 32'h22, 2'd0, 1'b0};
        tbl[3] = '{1'b1, 2'b01, 32'hA0, 32'h0,  1'b1, 1'b0, 1'b0, 32'h0,  32'h0,  2'd1, 1'b0};
        tbl[4] = '{1'b1, 2'b11, 32'hB0, 32'hA1, 1'b1, 1'b0, 1'b0, 32'h0,  32'h0,  2'd1, 1'b0};
        tbl[5] = '{1'b1, 2'b10, 32'h0,  32'hB1, 1'b1, 1'b0, 1'b1, 32'hA0, 32'hA1, 2'd1, 1'b0};
        tbl[6] = '{1'b1, 2'b00, 32'h0,  32'h0,  1'b1, 1'b1, 1'b1, 32'hB0, 32'hB1, 2'd2, 1'b0};
        tbl[7] = '{1'b1, 2'b00, 32'h0,  32'h0,  1'b1, 1'b1, 1'b0, 32'h0,  32'h0,  2'd3, 1'b0};
        tbl[8] = '{1'b1, 2'b00, 32'h0,  32'h0,  1'b1, 1'b1, 1'b0, 32'h0,  32'h0,  2'd3, 1'b1};

        out_ready = 1'b1;
        model_reset();
        do_reset();
        chk("reset_out_valid", smp_valid, 1'b0);
        chk("reset_overflow", smp_ovf, 1'b0);
        pulse_start();

        // Basic deskew then back-to-back rows into DONE
        for (int i = 0; i < 9; i++) begin
            general_enable = tbl[i].en;
            col_valid      = tbl[i].v;
            col_data       = {tbl[i].c1, tbl[i].c0};
            out_ready      = tbl[i].rdy;
            sched_done     = tbl[i].done;
            tick();
            chk($sformatf("vec%0d_out_valid", i), smp_valid, tbl[i].e_ov);
            if (tbl[i].e_ov) chk($sformatf("vec%0d_out_data", i), smp_data, {tbl[i].e_d1, tbl[i].e_d0});
            chk($sformatf("vec%0d_row_idx", i), smp_idx, tbl[i].e_idx);
            chk($sformatf("vec%0d_all_rows_out", i), smp_all, tbl[i].e_all);
        end

        // Backpressure and overflow
        do_reset();
        out_ready = 1'b0;
        feed_rows(5, 32'h100);
        tick();
        chk("bp_overflow", smp_ovf, 1'b1);
        drain(cnt, first, last);
        chk("bp_row_count", cnt, 4);
        chk("bp_first_row", first, {32'h101, 32'h100});
        chk("bp_last_row", last, {32'h107, 32'h106});

        // Full with simultaneous pop
        do_reset();
        out_ready = 1'b0;
        feed_rows(4, 32'h200);
        col_valid = 2'b01; col_data = {32'h0, 32'h208};
        tick();
        col_valid = 2'b10; col_data = {32'h209, 32'h0}; out_ready = 1'b1;
        tick();
        col_valid = '0; col_data = '0; out_ready = 1'b0;
        tick();
        chk("fullpop_overflow", smp_ovf, 1'b0);
        drain(cnt, first, last);
        chk("fullpop_row_count", cnt, 4);
        chk("fullpop_first_row", first, {32'h203, 32'h202});
        chk("fullpop_last_row", last, {32'h209, 32'h208});

        // Skew fault
        do_reset();
        out_ready = 1'b0;
        col_valid = 2'b01; col_data = {32'h0, 32'h1};
        tick();
        tick();
        col_valid = '0;
        tick();
        chk("skew_err_set", smp_skew, 1'b1);
        chk("skew_no_push", smp_valid, 1'b0);

        // Enable stall mid-row
        pulse_start();
        col_valid = 2'b01; col_data = {32'h0, 32'h33};
        tick();
        general_enable = 1'b0; col_valid = '0; col_data = '0;
        repeat (3) tick();
        general_enable = 1'b1; col_valid = 2'b10; col_data = {32'h44, 32'h0};
        tick();
        col_valid = '0; col_data = '0;
        tick();
        chk("stall_out_valid", smp_valid, 1'b1);
        chk("stall_out_data", smp_data, {32'h44, 32'h33});
        chk("stall_skew_clear", smp_skew, 1'b0);

        // Reset mid-DRAIN
        do_reset();
        out_ready = 1'b0;
        feed_rows(2, 32'h300);
        sched_done = 1'b1;
        tick();
        tick();
        chk("drain_not_done", smp_all, 1'b0);
        chk("drain_holding", smp_valid, 1'b1);
        reset = 1'b1;
        tick();
        chk("rst_out_valid", smp_valid, 1'b0);
        chk("rst_out_data", smp_data, 64'h0);
        chk("rst_all_rows_out", smp_all, 1'b0);
        reset = 1'b0; sched_done = 1'b0;
        tick();
        chk("rst_fifo_empty", smp_valid, 1'b0);

        // Only one row before DONE
        do_reset();
        out_ready = 1'b1;
        feed_rows(1, 32'h400);
        sched_done = 1'b1;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            tick();
            if (smp_all) got = 1;
        end
        chk("rc_done_reached", got, 1'b1);
`ifdef RESULT_ROWCHECK_EN
        chk("rc_row_count_err", smp_rce, 1'b1);
`else
        chk("rc_row_count_err", smp_rce, 1'b0);
`endif
        sched_done = 1'b0;

        // Randomized traffic against the model
        do_reset();
        for (int i = 0; i < 600; i++) begin
            reset          = ($urandom_range(0, 99) == 0);
            start          = ($urandom_range(0, 49) == 0);
            general_enable = ($urandom_range(0, 7) != 0);
            out_ready      = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 29) == 0) sched_done = ~sched_done;
            col_valid      = ($urandom_range(0, 2) != 0) ? 2'b11 : 2'($urandom_range(0, 3));
            col_data       = {$urandom(), $urandom()};
            tick();
        end
        reset = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
